// File: rtl/sram_arbiter.sv
// Two-requester arbiter for the shared 16-bit off-chip SRAM.
// The VGA fetcher has fixed priority. The host is guaranteed a grant after at
// most VGA_BURST_MAX consecutive VGA grants while it waits. Every access takes
// two cycles, and the SRAM strobes are registered from next-state logic.
module sram_arbiter #(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 16,
  parameter int VGA_BURST_MAX = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_vga_req,
  input  logic [ADDR_W-1:0] i_vga_addr,
  output logic              o_vga_gnt,
  output logic              o_vga_rvalid,
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  input  logic [1:0]        i_host_be,
  output logic              o_host_gnt,
  output logic              o_host_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_dq,
  output logic              o_sram_dq_oe,
  input  logic [DATA_W-1:0] i_sram_dq,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);

  localparam int              SW         = $clog2(VGA_BURST_MAX + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(VGA_BURST_MAX);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_A, WR_B} state_t;

  state_t      state, state_nxt;
  logic [SW-1:0] streak;
  logic        owner_vga;
  logic [1:0]  be_q, be_nxt;
  logic        arb_pt, host_pri, vga_win, host_win;
  logic        ce_nxt, oe_nxt, we_nxt, lb_nxt, ub_nxt, dq_oe_nxt;

  // Winner selection at the arbitration points; requests are ignored in reset
  always_comb begin
    arb_pt   = i_rst_n && (state == IDLE || state == RD_B || state == WR_B);
    host_pri = i_host_req && (streak == STREAK_MAX);
    vga_win  = arb_pt && i_vga_req && !host_pri;
    host_win = arb_pt && i_host_req && !vga_win;
  end

  assign o_vga_gnt  = vga_win;
  assign o_host_gnt = host_win;

  // Next state plus the strobe values that state will present on the pads
  always_comb begin
    state_nxt = state;
    ce_nxt    = 1'b1;
    oe_nxt    = 1'b1;
    we_nxt    = 1'b1;
    lb_nxt    = 1'b1;
    ub_nxt    = 1'b1;
    dq_oe_nxt = 1'b0;
    be_nxt    = host_win ? i_host_be : be_q;
    case (state)
      IDLE, RD_B, WR_B: begin
        if (vga_win)       state_nxt = RD_A;
        else if (host_win) state_nxt = i_host_we ? WR_A : RD_A;
        else               state_nxt = IDLE;
      end
      RD_A:    state_nxt = RD_B;
      WR_A:    state_nxt = WR_B;
      default: state_nxt = IDLE;
    endcase
    case (state_nxt)
      RD_A, RD_B: begin
        ce_nxt = 1'b0;
        oe_nxt = 1'b0;
        lb_nxt = 1'b0;
        ub_nxt = 1'b0;
      end
      WR_A: begin
        ce_nxt    = 1'b0;
        we_nxt    = 1'b0;
        dq_oe_nxt = 1'b1;
        lb_nxt    = ~be_nxt[0];
        ub_nxt    = ~be_nxt[1];
      end
      WR_B: begin
        // we_n released first; address and data stay driven for hold time
        ce_nxt    = 1'b0;
        dq_oe_nxt = 1'b1;
        lb_nxt    = ~be_nxt[0];
        ub_nxt    = ~be_nxt[1];
      end
      default: ;
    endcase
  end

  // State, pad registers, request latches, read capture and starvation counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      o_sram_ce_n   <= 1'b1;
      o_sram_oe_n   <= 1'b1;
      o_sram_we_n   <= 1'b1;
      o_sram_lb_n   <= 1'b1;
      o_sram_ub_n   <= 1'b1;
      o_sram_dq_oe  <= 1'b0;
      o_sram_addr   <= '0;
      o_sram_dq     <= '0;
      o_rdata       <= '0;
      o_vga_rvalid  <= 1'b0;
      o_host_rvalid <= 1'b0;
      owner_vga     <= 1'b0;
      be_q          <= 2'b00;
      streak        <= '0;
    end else begin
      state        <= state_nxt;
      o_sram_ce_n  <= ce_nxt;
      o_sram_oe_n  <= oe_nxt;
      o_sram_we_n  <= we_nxt;
      o_sram_lb_n  <= lb_nxt;
      o_sram_ub_n  <= ub_nxt;
      o_sram_dq_oe <= dq_oe_nxt;
      if (vga_win) begin
        o_sram_addr <= i_vga_addr;
        owner_vga   <= 1'b1;
      end else if (host_win) begin
        o_sram_addr <= i_host_addr;
        o_sram_dq   <= i_host_wdata;
        be_q        <= i_host_be;
        owner_vga   <= 1'b0;
      end
      if (state == RD_B) o_rdata <= i_sram_dq;
      o_vga_rvalid  <= (state == RD_B) &&  owner_vga;
      o_host_rvalid <= (state == RD_B) && !owner_vga;
      if (!i_host_req || host_win)           streak <= '0;
      else if (vga_win && streak != STREAK_MAX) streak <= streak + 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM on the pads, directed scenarios,
// then randomized traffic checked cycle by cycle against a transaction model.
module tb_sram_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int BM = 8;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_vga_req = 1'b0;
  logic [AW-1:0] i_vga_addr = '0;
  logic          o_vga_gnt, o_vga_rvalid;
  logic          i_host_req, i_host_we;
  logic [AW-1:0] i_host_addr;
  logic [DW-1:0] i_host_wdata;
  logic [1:0]    i_host_be;
  logic          o_host_gnt, o_host_rvalid;
  logic [DW-1:0] o_rdata, o_sram_dq, i_sram_dq;
  logic [AW-1:0] o_sram_addr;
  logic          o_sram_dq_oe, o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n;

  always #5 i_clk = ~i_clk;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .VGA_BURST_MAX(BM)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_vga_req(i_vga_req), .i_vga_addr(i_vga_addr), .o_vga_gnt(o_vga_gnt), .o_vga_rvalid(o_vga_rvalid),
    .i_host_req(i_host_req), .i_host_we(i_host_we), .i_host_addr(i_host_addr),
    .i_host_wdata(i_host_wdata), .i_host_be(i_host_be), .o_host_gnt(o_host_gnt), .o_host_rvalid(o_host_rvalid),
    .o_rdata(o_rdata), .o_sram_addr(o_sram_addr), .o_sram_dq(o_sram_dq), .o_sram_dq_oe(o_sram_dq_oe),
    .i_sram_dq(i_sram_dq), .o_sram_ce_n(o_sram_ce_n), .o_sram_oe_n(o_sram_oe_n), .o_sram_we_n(o_sram_we_n),
    .o_sram_lb_n(o_sram_lb_n), .o_sram_ub_n(o_sram_ub_n)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] pat(input int i);
    return 16'h5A00 ^ 16'(i * 16'h0137);
  endfunction

  // ---------------- pad-side SRAM model (32 words, aliased on addr[4:0])
  logic [DW-1:0] sram_mem [32];
  bit            mem_init = 1'b0;

  always @(posedge i_clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) sram_mem[i] <= pat(i);
      mem_init <= 1'b1;
    end else if (!o_sram_ce_n && !o_sram_we_n) begin
      if (!o_sram_lb_n) sram_mem[o_sram_addr[4:0]][7:0]  <= o_sram_dq[7:0];
      if (!o_sram_ub_n) sram_mem[o_sram_addr[4:0]][15:8] <= o_sram_dq[15:8];
    end
  end

  assign i_sram_dq = (!o_sram_ce_n && !o_sram_oe_n) ? sram_mem[o_sram_addr[4:0]] : '0;

  // ---------------- transaction-level reference model
  typedef struct {
    int          due;
    bit          vga;
    logic [15:0] data;
  } rd_t;

  rd_t           pend[$];
  logic [15:0]   ref_mem [32];
  bit            ref_init = 1'b0;
  bit            rst_edge = 1'b0;
  bit            mon_on = 1'b0;
  int            cyc = 0, next_arb = 0, streak_m = 0, lg = -100;
  bit            lg_we;
  logic [AW-1:0] lg_addr;
  logic [DW-1:0] lg_data;
  logic [1:0]    lg_be;

  // remembers whether the edge that started the current cycle was a reset edge
  always @(posedge i_clk) rst_edge <= !i_rst_n;

  always @(negedge i_clk) begin
    bit  arb, hp, vw, hw, ev, eh;
    logic [15:0] ed;
    rd_t r;
    if (!ref_init) begin
      for (int i = 0; i < 32; i++) ref_mem[i] = pat(i);
      ref_init = 1'b1;
    end
    cyc++;
    mon_on = mon_on | rst_edge;
    if (rst_edge) begin
      for (int i = pend.size() - 1; i >= 0; i--)
        if (pend[i].due >= cyc) pend.delete(i);
      next_arb = cyc;
      lg       = -100;
      streak_m = 0;
    end
    if (mon_on) begin
      ev = 1'b0; eh = 1'b0; ed = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r = pend.pop_front();
        ev = r.vga; eh = !r.vga; ed = r.data;
      end
      chk("vga_rvalid", 32'(o_vga_rvalid), 32'(ev));
      chk("host_rvalid", 32'(o_host_rvalid), 32'(eh));
      if (ev || eh) chk("rdata", 32'(o_rdata), 32'(ed));
      // pad activity expected in the two cycles after a grant
      if (cyc - lg == 1 || cyc - lg == 2) begin
        chk("sram_addr", 32'(o_sram_addr), 32'(lg_addr));
        chk("ce_n", 32'(o_sram_ce_n), 0);
        if (lg_we && cyc - lg == 1) begin
          chk("wr1_we_n", 32'(o_sram_we_n), 0);
          chk("wr1_oe_n", 32'(o_sram_oe_n), 1);
          chk("wr1_dq_oe", 32'(o_sram_dq_oe), 1);
          chk("wr1_lb_n", 32'(o_sram_lb_n), 32'(!lg_be[0]));
          chk("wr1_ub_n", 32'(o_sram_ub_n), 32'(!lg_be[1]));
          chk("wr1_dq", 32'(o_sram_dq), 32'(lg_data));
        end else if (lg_we) begin
          chk("wr2_we_n", 32'(o_sram_we_n), 1);
          chk("wr2_dq_oe", 32'(o_sram_dq_oe), 1);
          chk("wr2_dq", 32'(o_sram_dq), 32'(lg_data));
        end else begin
          chk("rd_we_n", 32'(o_sram_we_n), 1);
          chk("rd_oe_n", 32'(o_sram_oe_n), 0);
          chk("rd_dq_oe", 32'(o_sram_dq_oe), 0);
          chk("rd_lbub_n", 32'({o_sram_ub_n, o_sram_lb_n}), 0);
        end
      end else begin
        chk("idle_strobes", 32'({o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n}), 32'h1f);
        chk("idle_dq_oe", 32'(o_sram_dq_oe), 0);
      end
      arb = i_rst_n && cyc >= next_arb;
      hp  = i_host_req && streak_m == BM;
      vw  = arb && i_vga_req && !hp;
      hw  = arb && i_host_req && !vw;
      chk("vga_gnt", 32'(o_vga_gnt), 32'(vw));
      chk("host_gnt", 32'(o_host_gnt), 32'(hw));
      if (vw) begin
        next_arb = cyc + 2; lg = cyc; lg_we = 1'b0; lg_addr = i_vga_addr;
        r.due = cyc + 3; r.vga = 1'b1; r.data = ref_mem[i_vga_addr[4:0]];
        pend.push_back(r);
      end else if (hw) begin
        next_arb = cyc + 2; lg = cyc; lg_we = i_host_we; lg_addr = i_host_addr;
        lg_data = i_host_wdata; lg_be = i_host_be;
        if (i_host_we) begin
          if (i_host_be[0]) ref_mem[i_host_addr[4:0]][7:0]  = i_host_wdata[7:0];
          if (i_host_be[1]) ref_mem[i_host_addr[4:0]][15:8] = i_host_wdata[15:8];
        end else begin
          r.due = cyc + 3; r.vga = 1'b0; r.data = ref_mem[i_host_addr[4:0]];
          pend.push_back(r);
        end
      end
      if (!i_host_req || hw) streak_m = 0;
      else if (vw && streak_m < BM) streak_m++;
    end
  end

  // ---------------- VGA requester: 0 off, 1 continuous, 2 random; one-shots via shot_req
  int vga_mode = 0;
  int shot_req = 0;
  int shot_done = 0;
  bit vga_g;

  always begin
    @(negedge i_clk);
    vga_g = o_vga_gnt;
    @(posedge i_clk);
    #2;
    if (!(i_vga_req && !vga_g)) begin
      i_vga_req = 1'b0;
      if (vga_mode == 1 || (vga_mode == 2 && $urandom_range(0, 1) == 1) || shot_done < shot_req) begin
        i_vga_req  = 1'b1;
        i_vga_addr = AW'($urandom);
        if (shot_done < shot_req) shot_done++;
      end
    end
  end

  // ---------------- host driver helpers (entered and left at posedge+1)
  task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [1:0] be, output int vgn, output int w);
    bit got;
    i_host_req = 1'b1; i_host_we = we; i_host_addr = a; i_host_wdata = d; i_host_be = be;
    vgn = 0; w = 0; got = 1'b0;
    while (!got && w < 200) begin
      @(negedge i_clk);
      w++;
      if (o_vga_gnt) vgn++;
      if (o_host_gnt) got = 1'b1;
    end
    if (!got) chk("host_gnt_timeout", 0, 1);
    @(posedge i_clk);
    #1;
    i_host_req = 1'b0;
  endtask

  task automatic read_expect(input string tag, input logic [DW-1:0] exp);
    repeat (3) @(negedge i_clk);
    chk({tag, "_rvalid"}, 32'(o_host_rvalid), 1);
    chk({tag, "_rdata"}, 32'(o_rdata), 32'(exp));
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  initial begin
    int vgn, w, gn, rv, hr;
    bit seen;
    i_rst_n = 1'b0;
    i_host_req = 1'b1;   // must be ignored while in reset
    i_host_we = 1'b0; i_host_addr = '0; i_host_wdata = '0; i_host_be = 2'b11;
    repeat (3) @(negedge i_clk);
    chk("rst_host_gnt", 32'(o_host_gnt), 0);
    chk("rst_addr", 32'(o_sram_addr), 0);
    chk("rst_rdata", 32'(o_rdata), 0);
    chk("rst_strobes", 32'({o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n}), 32'h1f);
    chk("rst_dq_oe", 32'(o_sram_dq_oe), 0);
    @(posedge i_clk);
    #1;
    i_host_req = 1'b0;
    i_rst_n = 1'b1;
    idle(3);

    // write then read back the same word
    host_op(1'b1, 20'h00010, 16'hBEEF, 2'b11, vgn, w);
    @(negedge i_clk);
    chk("t1_wr_we_n", 32'(o_sram_we_n), 0);
    @(posedge i_clk);
    #1;
    host_op(1'b0, 20'h00010, 16'h0, 2'b00, vgn, w);
    read_expect("t1", 16'hBEEF);

    // lower-byte-only write over 0xFFFF
    host_op(1'b1, 20'h00020, 16'hFFFF, 2'b11, vgn, w);
    host_op(1'b1, 20'h00020, 16'h1234, 2'b01, vgn, w);
    @(negedge i_clk);
    chk("t4_ub_n", 32'(o_sram_ub_n), 1);
    chk("t4_lb_n", 32'(o_sram_lb_n), 0);
    @(posedge i_clk);
    #1;
    host_op(1'b0, 20'h00020, 16'h0, 2'b00, vgn, w);
    read_expect("t4", 16'hFF34);

    // continuous VGA traffic with the host idle
    idle(2);
    vga_mode = 1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge i_clk);
      seen = o_vga_gnt;
    end
    chk("t2_first_gnt", 32'(seen), 1);
    gn = 1; rv = 32'(o_vga_rvalid); hr = 32'(o_host_rvalid);
    repeat (39) begin
      @(negedge i_clk);
      gn += 32'(o_vga_gnt); rv += 32'(o_vga_rvalid); hr += 32'(o_host_rvalid);
    end
    chk("t2_vga_gnts", 32'(gn), 20);
    chk("t2_vga_rvalids", 32'(rv), 19);
    chk("t2_host_rvalids", 32'(hr), 0);
    @(posedge i_clk);
    #1;

    // host read against continuous VGA: bounded burst, pattern repeats
    for (int k = 0; k < 3; k++) begin
      host_op(1'b0, AW'($urandom_range(0, 31)), 16'h0, 2'b00, vgn, w);
      chk("t3_vga_burst", 32'(vgn), BM);
    end
    vga_mode = 0;
    idle(6);

    // simultaneous rise from idle: VGA first, host at the following RD_B
    shot_req++;
    host_op(1'b0, 20'h00003, 16'h0, 2'b00, vgn, w);
    chk("t6_vga_first", 32'(vgn), 1);
    chk("t6_host_wait", 32'(w), 3);
    idle(6);

    // reset asserted during RD_A of a host read
    host_op(1'b0, 20'h00010, 16'h0, 2'b00, vgn, w);
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("t5_strobes", 32'({o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n}), 32'h1f);
    chk("t5_dq_oe", 32'(o_sram_dq_oe), 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("t5_no_rvalid", 32'(o_host_rvalid), 0);
    @(posedge i_clk);
    #1;
    host_op(1'b0, 20'h00010, 16'h0, 2'b00, vgn, w);
    read_expect("t5_after", 16'hBEEF);

    // randomized mixed traffic
    vga_mode = 2;
    for (int k = 0; k < 150; k++) begin
      host_op(1'($urandom), {15'($urandom), 5'($urandom_range(0, 31))}, 16'($urandom),
              2'($urandom), vgn, w);
      idle($urandom_range(0, 3));
    end
    vga_mode = 0;
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
